stopwatch_bcd: RTL and testbench

STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

---
 rtl/stopwatch_pkg.sv | 24 ++
 rtl/bcd_digit_counter.sv | 59 +++++
 rtl/stopwatch_bcd.sv | 165 ++++++++++++++++
 tb/tb_stopwatch_bcd.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch.
// FSM state encoding, BCD digit type and wrap limits.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    typedef logic [3:0] bcd_t;

    localparam int CS_MAX  = 99;
    localparam int SEC_MAX = 59;

    function automatic bcd_t bcd_tens(int v);
        return bcd_t'(v / 10);
    endfunction

    function automatic bcd_t bcd_ones(int v);
        return bcd_t'(v % 10);
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Two-digit BCD counter modulo MAX+1 with terminal count.
// With sat high an increment at terminal count holds instead of wrapping.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX = 99
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    input  logic sat,
    output bcd_t tens,
    output bcd_t ones,
    output logic tc
);

    localparam bcd_t MAX_T = bcd_tens(MAX);
    localparam bcd_t MAX_O = bcd_ones(MAX);

    bcd_t tens_q, tens_d;
    bcd_t ones_q, ones_d;

    assign tc   = (tens_q == MAX_T) && (ones_q == MAX_O);
    assign tens = tens_q;
    assign ones = ones_q;

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (clr) begin
            tens_d = '0;
            ones_d = '0;
        end else if (inc) begin
            if (tc) begin
                if (!sat) begin
                    tens_d = '0;
                    ones_d = '0;
                end
            end else if (ones_q == 4'd9) begin
                ones_d = '0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens_q <= '0;
            ones_q <= '0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

endmodule

// File: rtl/stopwatch_bcd.sv
// BCD stopwatch MM:SS.cc counted from a synchronised 100 Hz tick.
// Optional lap freeze enabled by defining STOPWATCH_LAP_EN.
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_LIMIT   = 59
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic       clk_100Hz,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] cs_tens,
    output logic [3:0] cs_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic       running,
    output logic       lap_active,
    output logic       overflow
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic                   tick;

    state_e state_q, state_d;
    logic   overflow_q, overflow_d;

    logic   run_tick, sat_all, saturate;
    logic   cs_tc, sec_tc, min_tc;
    bcd_t   cs_t, cs_o, sec_t, sec_o, min_t, min_o;
    logic [23:0] live;
    logic [23:0] shown;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], clk_100Hz};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    assign tick = sync_q[SYNC_STAGES-1] & ~hist_q;

    assign run_tick = tick & (state_q == RUN) & ~clear;
    assign sat_all  = cs_tc & sec_tc & min_tc;
    assign saturate = run_tick & sat_all;

    always_comb begin
        state_d    = state_q;
        overflow_d = overflow_q;
        if (clear) begin
            state_d    = IDLE;
            overflow_d = 1'b0;
        end else if (saturate) begin
            state_d    = PAUSE;
            overflow_d = 1'b1;
        end else if (start_stop && !overflow_q) begin
            unique case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            sync_q     <= '0;
            hist_q     <= 1'b0;
            state_q    <= IDLE;
            overflow_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            hist_q     <= hist_d;
            state_q    <= state_d;
            overflow_q <= overflow_d;
        end
    end

    // Every stage sees sat_all so the whole count freezes together.
    bcd_digit_counter #(.MAX(CS_MAX)) u_cs (
        .clk  (clk_50MHz),
        .rst  (reset),
        .inc  (run_tick),
        .clr  (clear),
        .sat  (sat_all),
        .tens (cs_t),
        .ones (cs_o),
        .tc   (cs_tc)
    );

    bcd_digit_counter #(.MAX(SEC_MAX)) u_sec (
        .clk  (clk_50MHz),
        .rst  (reset),
        .inc  (run_tick & cs_tc),
        .clr  (clear),
        .sat  (sat_all),
        .tens (sec_t),
        .ones (sec_o),
        .tc   (sec_tc)
    );

    bcd_digit_counter #(.MAX(MIN_LIMIT)) u_min (
        .clk  (clk_50MHz),
        .rst  (reset),
        .inc  (run_tick & cs_tc & sec_tc),
        .clr  (clear),
        .sat  (sat_all),
        .tens (min_t),
        .ones (min_o),
        .tc   (min_tc)
    );

    assign live = {min_t, min_o, sec_t, sec_o, cs_t, cs_o};

`ifdef STOPWATCH_LAP_EN
    logic        lap_active_q, lap_active_d;
    logic [23:0] lap_val_q, lap_val_d;

    always_comb begin
        lap_active_d = lap_active_q;
        lap_val_d    = lap_val_q;
        if (clear) begin
            lap_active_d = 1'b0;
        end else if (lap) begin
            if (state_q == RUN) begin
                lap_active_d = ~lap_active_q;
                if (!lap_active_q) begin
                    lap_val_d = live;
                end
            end else begin
                lap_active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            lap_active_q <= 1'b0;
            lap_val_q    <= '0;
        end else begin
            lap_active_q <= lap_active_d;
            lap_val_q    <= lap_val_d;
        end
    end

    assign shown      = lap_active_q ? lap_val_q : live;
    assign lap_active = lap_active_q;
`else
    logic lap_unused;

    assign lap_unused = lap;
    assign shown      = live;
    assign lap_active = 1'b0;
`endif

    assign {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones} = shown;

    assign running  = (state_q == RUN);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Self-checking bench for stopwatch_bcd (MIN_LIMIT=1).
// Vector table with checkpoints plus a per-step model scoreboard.
module tb_stopwatch_bcd;

    localparam int MINL = 1;
    localparam int TMAX = (MINL * 60 + 59) * 100 + 99;

    logic clk = 1'b0;
    logic reset, clk_100, ss, clr, lp;
    logic [3:0] cs_tens, cs_ones, sec_tens, sec_ones;
    logic [3:0] min_tens, min_ones;
    logic running, lap_active, overflow;
    logic [23:0] dout;

    always #10 clk = ~clk;

    stopwatch_bcd #(
        .SYNC_STAGES (2),
        .MIN_LIMIT   (MINL)
    ) dut (
        .clk_50MHz  (clk),
        .reset      (reset),
        .clk_100Hz  (clk_100),
        .start_stop (ss),
        .clear      (clr),
        .lap        (lp),
        .cs_tens    (cs_tens),
        .cs_ones    (cs_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .running    (running),
        .lap_active (lap_active),
        .overflow   (overflow)
    );

    assign dout = {min_tens, min_ones, sec_tens, sec_ones,
                   cs_tens, cs_ones};

    typedef enum {OP_SS, OP_CLR, OP_LAP, OP_TICK, OP_TICKSS,
                  OP_SSCLR} op_e;

    typedef struct {
        op_e op;
        int  n;
        int  e_min;
        int  e_sec;
        int  e_cs;
        bit  e_run;
        bit  e_ovf;
        bit  e_lap;
    } vec_t;

    typedef struct {
        logic [23:0] d;
        logic        run;
        logic        ovf;
        logic        lap;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int m_t = 0;
    int m_state = 0;
    int m_lap_t = 0;
    bit m_ovf = 0;
    bit m_lapa = 0;

    function automatic logic [23:0] dig(int m, int s, int c);
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
                4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic logic [23:0] dig_t(int t);
        return dig(t / 6000, (t / 100) % 60, t % 100);
    endfunction

    task automatic chk(string name, logic [23:0] got,
                       logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, got, exp, $time);
        end
    endtask

    task automatic model_step(bit s, bit c, bit l, bit tk);
        bit   sat;
        int   cur;
        exp_t e;
        if (c) begin
            m_state = 0;
            m_t     = 0;
            m_ovf   = 0;
            m_lapa  = 0;
        end else begin
            cur = m_t;
            sat = tk && m_state == 1 && m_t == TMAX;
            if (tk && m_state == 1 && !sat) m_t++;
`ifdef STOPWATCH_LAP_EN
            if (l) begin
                if (m_state == 1) begin
                    if (!m_lapa) m_lap_t = cur;
                    m_lapa = !m_lapa;
                end else begin
                    m_lapa = 0;
                end
            end
`else
            if (l) m_lapa = 0;
`endif
            if (sat) begin
                m_ovf   = 1;
                m_state = 2;
            end else if (s && !m_ovf) begin
                m_state = (m_state == 1) ? 2 : 1;
            end
        end
        e.d   = m_lapa ? dig_t(m_lap_t) : dig_t(m_t);
        e.run = (m_state == 1);
        e.ovf = m_ovf;
        e.lap = m_lapa;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic ok;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_digits", dout, e.d);
            chk("sb_running", 24'(running), 24'(e.run));
            chk("sb_overflow", 24'(overflow), 24'(e.ovf));
            chk("sb_lap", 24'(lap_active), 24'(e.lap));
            ok = (cs_tens <= 9) && (cs_ones <= 9) &&
                 (sec_tens <= 9) && (sec_ones <= 9) &&
                 (min_tens <= 9) && (min_ones <= 9);
            chk("digit_range", 24'(ok), 24'(1));
        end
    endtask

    task automatic do_cmd(bit s, bit c, bit l);
        drain();
        ss  = s;
        clr = c;
        lp  = l;
        @(negedge clk);
        ss  = 1'b0;
        clr = 1'b0;
        lp  = 1'b0;
        model_step(s, c, l, 1'b0);
    endtask

    // Rising edge at the start; tick reaches the counter two cycles on.
    task automatic do_tick(bit s);
        drain();
        clk_100 = 1'b1;
        @(negedge clk);
        clk_100 = 1'b0;
        @(negedge clk);
        ss = s;
        @(negedge clk);
        ss = 1'b0;
        model_step(s, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic add(op_e op, int n, int mi, int se, int cs,
                       bit r, bit o, bit l);
        vec_t v;
        v.op    = op;
        v.n     = n;
        v.e_min = mi;
        v.e_sec = se;
        v.e_cs  = cs;
        v.e_run = r;
        v.e_ovf = o;
        v.e_lap = l;
        vt.push_back(v);
    endtask

    initial begin
        reset   = 1'b1;
        clk_100 = 1'b0;
        ss      = 1'b0;
        clr     = 1'b0;
        lp      = 1'b0;

        add(OP_SS,     1,    0,  0,  0, 1, 0, 0);
        add(OP_TICK,   100,  0,  1,  0, 1, 0, 0);
        add(OP_TICK,   5899, 0, 59, 99, 1, 0, 0);
        add(OP_TICK,   1,    1,  0,  0, 1, 0, 0);
        add(OP_TICK,   5999, 1, 59, 99, 1, 0, 0);
        add(OP_TICK,   1,    1, 59, 99, 0, 1, 0);
        add(OP_SS,     1,    1, 59, 99, 0, 1, 0);
        add(OP_TICK,   3,    1, 59, 99, 0, 1, 0);
        add(OP_CLR,    1,    0,  0,  0, 0, 0, 0);
        add(OP_SS,     1,    0,  0,  0, 1, 0, 0);
        add(OP_TICK,   37,   0,  0, 37, 1, 0, 0);
        add(OP_SSCLR,  1,    0,  0,  0, 0, 0, 0);
        add(OP_TICK,   5,    0,  0,  0, 0, 0, 0);
        add(OP_SS,     1,    0,  0,  0, 1, 0, 0);
        add(OP_TICK,   10,   0,  0, 10, 1, 0, 0);
        add(OP_TICKSS, 1,    0,  0, 11, 0, 0, 0);
        add(OP_TICK,   4,    0,  0, 11, 0, 0, 0);
        add(OP_SS,     1,    0,  0, 11, 1, 0, 0);
        add(OP_TICK,   9,    0,  0, 20, 1, 0, 0);
        add(OP_CLR,    1,    0,  0,  0, 0, 0, 0);
        add(OP_SS,     1,    0,  0,  0, 1, 0, 0);
        add(OP_TICK,   250,  0,  2, 50, 1, 0, 0);
`ifdef STOPWATCH_LAP_EN
        add(OP_LAP,    1,    0,  2, 50, 1, 0, 1);
        add(OP_TICK,   50,   0,  2, 50, 1, 0, 1);
        add(OP_LAP,    1,    0,  3,  0, 1, 0, 0);
        add(OP_LAP,    1,    0,  3,  0, 1, 0, 1);
        add(OP_TICK,   10,   0,  3,  0, 1, 0, 1);
        add(OP_SS,     1,    0,  3,  0, 0, 0, 1);
        add(OP_LAP,    1,    0,  3, 10, 0, 0, 0);
        add(OP_LAP,    1,    0,  3, 10, 0, 0, 0);
        add(OP_SS,     1,    0,  3, 10, 1, 0, 0);
        add(OP_LAP,    1,    0,  3, 10, 1, 0, 1);
        add(OP_CLR,    1,    0,  0,  0, 0, 0, 0);
`else
        add(OP_LAP,    1,    0,  2, 50, 1, 0, 0);
        add(OP_TICK,   50,   0,  3,  0, 1, 0, 0);
        add(OP_CLR,    1,    0,  0,  0, 0, 0, 0);
`endif
        add(OP_SS,     1,    0,  0,  0, 1, 0, 0);
        add(OP_TICK,   500,  0,  5,  0, 1, 0, 0);

        repeat (3) @(negedge clk);
        chk("reset_digits", dout, 24'd0);
        chk("reset_running", 24'(running), 24'd0);
        chk("reset_overflow", 24'(overflow), 24'd0);
        chk("reset_lap", 24'(lap_active), 24'd0);
        reset = 1'b0;
        @(negedge clk);

        foreach (vt[i]) begin
            for (int k = 0; k < vt[i].n; k++) begin
                case (vt[i].op)
                    OP_SS:     do_cmd(1'b1, 1'b0, 1'b0);
                    OP_CLR:    do_cmd(1'b0, 1'b1, 1'b0);
                    OP_LAP:    do_cmd(1'b0, 1'b0, 1'b1);
                    OP_SSCLR:  do_cmd(1'b1, 1'b1, 1'b0);
                    OP_TICK:   do_tick(1'b0);
                    OP_TICKSS: do_tick(1'b1);
                    default:   do_tick(1'b0);
                endcase
            end
            drain();
            chk($sformatf("vec%0d_digits", i), dout,
                dig(vt[i].e_min, vt[i].e_sec, vt[i].e_cs));
            chk($sformatf("vec%0d_running", i),
                24'(running), 24'(vt[i].e_run));
            chk($sformatf("vec%0d_overflow", i),
                24'(overflow), 24'(vt[i].e_ovf));
            chk($sformatf("vec%0d_lap", i),
                24'(lap_active), 24'(vt[i].e_lap));
        end

        // Reset mid-run with clk_100Hz high across release.
        drain();
        clk_100 = 1'b1;
        reset   = 1'b1;
        #1;
        chk("async_rst_digits", dout, 24'd0);
        chk("async_rst_running", 24'(running), 24'd0);
        m_state = 0;
        m_t     = 0;
        m_ovf   = 0;
        m_lapa  = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        clk_100 = 1'b0;
        @(negedge clk);
        chk("post_rst_digits", dout, 24'd0);
        chk("post_rst_running", 24'(running), 24'd0);
        chk("post_rst_overflow", 24'(overflow), 24'd0);
        for (int k = 0; k < 5; k++) do_tick(1'b0);
        drain();
        chk("idle_no_count", dout, 24'd0);
        do_cmd(1'b1, 1'b0, 1'b0);
        do_tick(1'b0);
        drain();
        chk("post_rst_count", dout, dig(0, 0, 1));
        chk("post_rst_run", 24'(running), 24'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
